// File: rtl/coin_draw_ctrl.sv
// coin_draw_ctrl: coin slot table, spin-animation counter and a 3-stage
// sprite-ROM / palette lookup pipeline on the VGA pixel stream.
module coin_draw_ctrl #(
  parameter int unsigned NUM_COINS  = 8,
  parameter int unsigned SPR_W      = 16,
  parameter int unsigned SPR_H      = 16,
  parameter int unsigned NUM_FRAMES = 8,
  parameter int unsigned FRAME_DIV  = 6,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned ROM_AW     = 11
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pixel_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              frame_start,
  input  logic              spawn_valid,
  output logic              spawn_ready,
  input  logic [9:0]        spawn_x,
  input  logic [9:0]        spawn_y,
  input  logic              collect_valid,
  input  logic [3:0]        collect_slot,
  output logic [4:0]        coins_active,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        pal_index,
  output logic              coin_hit,
  output logic              pix_valid
);

  localparam int unsigned XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [NUM_COINS-1:0] r_valid;
  logic [9:0]           r_x [NUM_COINS];
  logic [9:0]           r_y [NUM_COINS];
  logic [FW-1:0]        r_frame;
  logic [DW-1:0]        r_div;
  logic                 r_s1_valid;
  logic                 r_s1_hit;
  logic                 r_s2_valid;
  logic                 r_s2_hit;

  logic [NUM_COINS-1:0] w_spawn_oh;
  logic [NUM_COINS-1:0] w_clr_oh;
  logic                 w_found;
  logic                 w_spawn_acc;
  logic                 w_hit;
  logic [XW-1:0]        w_dx;
  logic [YW-1:0]        w_dy;

  assign spawn_ready  = ~(&r_valid);
  assign w_spawn_acc  = spawn_valid & spawn_ready;

  // Lowest free slot (pre-collect map) and the effective collect mask.
  always_comb begin
    w_spawn_oh = '0;
    w_clr_oh   = '0;
    w_found    = 1'b0;
    for (int i = 0; i < int'(NUM_COINS); i++) begin
      if (!r_valid[i] && !w_found) begin
        w_spawn_oh[i] = 1'b1;
        w_found       = 1'b1;
      end
      w_clr_oh[i] = collect_valid && (collect_slot == 4'(i)) && r_valid[i];
    end
  end

  // Slot table and registered occupancy count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid      <= '0;
      coins_active <= '0;
      for (int i = 0; i < int'(NUM_COINS); i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_COINS); i++) begin
        if (w_clr_oh[i]) r_valid[i] <= 1'b0;
        if (w_spawn_acc && w_spawn_oh[i]) begin
          r_valid[i] <= 1'b1;
          r_x[i]     <= spawn_x;
          r_y[i]     <= spawn_y;
        end
      end
      coins_active <= coins_active + 5'(w_spawn_acc) - 5'(|w_clr_oh);
    end
  end

  // Spin animation: advance one frame every FRAME_DIV frame_start pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div   <= '0;
      r_frame <= '0;
    end else if (frame_start) begin
      if (r_div == DW'(FRAME_DIV - 1)) begin
        r_div   <= '0;
        r_frame <= r_frame + FW'(1);
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // Hit test; 11-bit compares keep cx+SPR_W from wrapping. Lowest index wins.
  always_comb begin
    w_hit = 1'b0;
    w_dx  = '0;
    w_dy  = '0;
    for (int i = int'(NUM_COINS) - 1; i >= 0; i--) begin
      if (r_valid[i] &&
          ({1'b0, DrawX} >= {1'b0, r_x[i]}) &&
          ({1'b0, DrawX} <  ({1'b0, r_x[i]} + 11'(SPR_W))) &&
          ({1'b0, DrawY} >= {1'b0, r_y[i]}) &&
          ({1'b0, DrawY} <  ({1'b0, r_y[i]} + 11'(SPR_H)))) begin
        w_hit = 1'b1;
        w_dx  = DrawX[XW-1:0] - r_x[i][XW-1:0];
        w_dy  = DrawY[YW-1:0] - r_y[i][YW-1:0];
      end
    end
  end

  // Three-stage pixel pipeline: address, ROM access, palette output.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_hit   <= 1'b0;
      rom_addr   <= '0;
      pal_index  <= '0;
      coin_hit   <= 1'b0;
      pix_valid  <= 1'b0;
    end else begin
      r_s1_valid <= pixel_en;
      r_s1_hit   <= pixel_en & w_hit;
      if (pixel_en && w_hit) rom_addr <= ROM_AW'({r_frame, w_dy, w_dx});
      r_s2_valid <= r_s1_valid;
      r_s2_hit   <= r_s1_hit;
      pix_valid  <= r_s2_valid;
      if (r_s2_valid) begin
        pal_index <= r_s2_hit ? rom_data : 8'(TRANSP_IDX);
        coin_hit  <= r_s2_hit && (rom_data != 8'(TRANSP_IDX));
      end
    end
  end

endmodule

// File: tb/tb_coin_draw_ctrl.sv
// Self-checking bench for coin_draw_ctrl: behavioural slot/animation model,
// synchronous ROM model and a scoreboard queue of expected pixel results.
module tb_coin_draw_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pixel_en;
  logic [9:0]  DrawX, DrawY;
  logic        frame_start;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [9:0]  spawn_x, spawn_y;
  logic        collect_valid;
  logic [3:0]  collect_slot;
  logic [4:0]  coins_active;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  pal_index;
  logic        coin_hit;
  logic        pix_valid;

  coin_draw_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .frame_start(frame_start), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .collect_valid(collect_valid),
    .collect_slot(collect_slot), .coins_active(coins_active), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_index(pal_index), .coin_hit(coin_hit), .pix_valid(pix_valid)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM, one cycle latency.
  logic [7:0] rom_mem [2048];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  // Reference model state.
  bit          m_valid [8];
  int          m_x [8];
  int          m_y [8];
  int          m_frame, m_div, m_count;
  logic [10:0] m_addr;
  bit          addr_pend;
  logic [8:0]  sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_any_free();
    for (int i = 0; i < 8; i++) if (!m_valid[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Returns {hit, address} for the lowest covering valid slot.
  function automatic logic [11:0] model_lookup(input int x, input int y);
    for (int i = 0; i < 8; i++) begin
      if (m_valid[i] && x >= m_x[i] && x < m_x[i] + 16 && y >= m_y[i] && y < m_y[i] + 16)
        return {1'b1, 11'(m_frame * 256 + (y - m_y[i]) * 16 + (x - m_x[i]))};
    end
    return 12'h000;
  endfunction

  // One clock: drive at negedge, update model, check state at next negedge.
  task automatic cycle(input bit pe, input int x, input int y, input bit fs,
                       input bit sv, input int sx, input int sy, input bit cv, input int cs);
    logic [11:0] lk;
    logic [7:0]  pal;
    int          free;
    pixel_en = pe; DrawX = 10'(x); DrawY = 10'(y); frame_start = fs;
    spawn_valid = sv; spawn_x = 10'(sx); spawn_y = 10'(sy);
    collect_valid = cv; collect_slot = 4'(cs);
    lk = model_lookup(x, y);
    if (pe) begin
      if (lk[11]) begin
        m_addr = lk[10:0];
        pal    = rom_mem[m_addr];
        sb_q.push_back({pal != 8'h00, pal});
      end else begin
        sb_q.push_back(9'h000);
      end
    end
    addr_pend = pe;
    free = -1;
    for (int i = 0; i < 8; i++) if (!m_valid[i] && free < 0) free = i;
    if (cv && cs < 8 && m_valid[cs]) begin m_valid[cs] = 1'b0; m_count--; end
    if (sv && free >= 0) begin m_valid[free] = 1'b1; m_x[free] = sx; m_y[free] = sy; m_count++; end
    if (fs) begin
      if (m_div == 5) begin m_div = 0; m_frame = (m_frame + 1) % 8; end
      else m_div++;
    end
    @(posedge Clk);
    @(negedge Clk);
    if (addr_pend) check_val("rom_addr", rom_addr, m_addr);
    check_val("coins_active", coins_active, m_count);
    check_val("spawn_ready", spawn_ready, m_any_free());
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic px(input int x, input int y);
    cycle(1, x, y, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic spawn(input int x, input int y);
    cycle(0, 0, 0, 0, 1, x, y, 0, 0);
  endtask
  task automatic collect(input int s);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, s);
  endtask
  task automatic fpulse(input int n);
    repeat (n) cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // Output monitor: every valid pixel must match the oldest expectation.
  always @(negedge Clk) begin
    logic [8:0] e;
    if (Reset_n === 1'b1 && pix_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val("pal_index", pal_index, e[7:0]);
        check_val("coin_hit", coin_hit, e[8]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    for (int a = 0; a < 2048; a++) rom_mem[a] = (a % 8 == 6) ? 8'h00 : 8'(a * 13 + 7);
    rom_mem[11'h023] = 8'h2A;
    for (int i = 0; i < 8; i++) begin m_valid[i] = 0; m_x[i] = 0; m_y[i] = 0; end
    m_frame = 0; m_div = 0; m_count = 0; m_addr = '0; addr_pend = 0;
    Reset_n = 1'b0; pixel_en = 0; DrawX = '0; DrawY = '0; frame_start = 0;
    spawn_valid = 0; spawn_x = '0; spawn_y = '0; collect_valid = 0; collect_slot = '0;
    @(negedge Clk); @(negedge Clk);
    check_val("rst_pix_valid", pix_valid, 0);
    check_val("rst_pal_index", pal_index, 0);
    check_val("rst_coin_hit", coin_hit, 0);
    check_val("rst_rom_addr", rom_addr, 0);
    Reset_n = 1'b1;
    idle(2);

    // Single coin lookup, opaque then transparent.
    spawn(100, 50);
    px(103, 52);
    idle(4);
    rom_mem[11'h023] = 8'h00;
    px(103, 52);
    idle(4);
    rom_mem[11'h023] = 8'h2A;

    // Fill the table, drop the 9th spawn.
    spawn(10, 12); spawn(200, 100); spawn(300, 200); spawn(15, 18);
    spawn(630, 300); spawn(400, 400); spawn(500, 450);
    spawn(700, 400);
    // Collect with same-cycle spawn while full: spawn dropped.
    cycle(0, 0, 0, 0, 1, 300, 300, 1, 3);
    spawn(250, 260);
    px(251, 262);
    collect(12);
    collect(6);
    collect(6);
    // Collect slot 7 with spawn: goes into freed slot 6, count unchanged.
    cycle(0, 0, 0, 0, 1, 400, 410, 1, 7);
    px(401, 411); px(501, 451);
    // Overlap priority and right screen edge.
    px(20, 20); px(639, 305); px(645, 305); px(646, 305); px(629, 305);
    px(25, 27); px(26, 20);
    idle(4);

    // Animation divider and wrap.
    fpulse(6);
    px(103, 52);
    fpulse(42);
    px(103, 52);
    idle(4);

    // Random traffic with bubbles and occasional frame pulses.
    for (int k = 0; k < 40; k++) begin
      s = int'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, m_x[s] + int'($urandom_range(0, 19)),
            m_y[s] + int'($urandom_range(0, 19)), $urandom_range(0, 7) == 0, 0, 0, 0, 0, 0);
    end
    idle(4);

    // Reset with three pixels in flight.
    px(103, 52); px(20, 20); px(639, 305);
    #2;
    Reset_n = 1'b0;
    pixel_en = 1'b0; spawn_valid = 1'b0; collect_valid = 1'b0; frame_start = 1'b0;
    #1;
    check_val("rst_mid_pix_valid", pix_valid, 0);
    check_val("rst_mid_coins", coins_active, 0);
    check_val("rst_mid_ready", spawn_ready, 1);
    check_val("rst_mid_rom_addr", rom_addr, 0);
    sb_q.delete();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    m_count = 0; m_frame = 0; m_div = 0; m_addr = '0; addr_pend = 0;
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    idle(3);
    px(103, 52);
    spawn(5, 5);
    px(6, 6);
    idle(5);

    check_val("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
